// File: rtl/config_write_fifo_register.sv
// rtl/config_write_fifo_register.sv - config-bus write capture into a typed FIFO stream
module config_write_fifo_register #(
    parameter int unsigned ADDR            = 0,
    parameter type         TYPE            = logic [31:0],
    parameter int          CONF_ADDR_WIDTH = 32,
    parameter int          CONF_DATA_WIDTH = 64,
    parameter int          DEPTH           = 4,
    parameter int          DROP_CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         conf_valid_i,
    input  logic [CONF_ADDR_WIDTH-1:0]   conf_addr_i,
    input  logic [CONF_DATA_WIDTH-1:0]   conf_data_i,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    output TYPE                          data_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   fill_o,
    output logic                         overflow_o,
    output logic [DROP_CNT_WIDTH-1:0]    drop_count_o
);

    localparam int W     = $bits(TYPE);
    localparam int CDW   = CONF_DATA_WIDTH;
    localparam int CAW   = CONF_ADDR_WIDTH;
    localparam int WORDS = (W + CDW - 1) / CDW;
    localparam int SW    = WORDS * CDW;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int FW    = $clog2(DEPTH + 1);

    localparam logic [CAW-1:0] BASE_A = CAW'(ADDR);
    localparam logic [CAW-1:0] LAST_A = BASE_A + CAW'(WORDS - 1);
    localparam logic [CAW-1:0] CTRL_A = BASE_A + CAW'(WORDS);

    // Staging is kept flat so the commit value is just its low W bits.
    logic [SW-1:0]             stage_q, stage_d;
    TYPE                       mem_q [DEPTH];
    logic [PW-1:0]             wr_q, wr_d, rd_q, rd_d;
    logic                      overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

    logic [CAW-1:0] offset;
    logic           hit_stage, commit, ctrl, clr, flush;
    logic           empty, full, pop_raw, pop, push, drop;
    TYPE            commit_val;

    assign offset    = conf_addr_i - BASE_A;
    assign hit_stage = conf_valid_i && (offset < CAW'(WORDS));
    assign commit    = conf_valid_i && (conf_addr_i == LAST_A);
    assign ctrl      = conf_valid_i && (conf_addr_i == CTRL_A);
    assign clr       = ctrl && conf_data_i[0];
    assign flush     = ctrl && conf_data_i[1];

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_raw = !empty && data_ready_i;
    // A flush discards the queue, so a coincident pop has no meaning.
    assign pop     = pop_raw && !flush;
    // A full FIFO still takes a commit when the head leaves in the same cycle.
    assign push    = commit && (!full || pop_raw);
    assign drop    = commit && !push;

    // Staging update: the addressed slice takes the write data, others hold.
    always_comb begin
        stage_d = stage_q;
        for (int i = 0; i < WORDS; i++) begin
            if (hit_stage && (offset == CAW'(i))) begin
                stage_d[i*CDW +: CDW] = conf_data_i;
            end
        end
    end

    // The committed value already includes the current write of the last word.
    assign commit_val = TYPE'(stage_d[W-1:0]);

    // Pointer and overflow bookkeeping.
    always_comb begin
        wr_d       = wr_q;
        rd_d       = rd_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
        end
        if (clr) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != {DROP_CNT_WIDTH{1'b1}}) drop_d = drop_q + DROP_CNT_WIDTH'(1);
        end
    end

    // State registers; memory is cleared too so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            stage_q    <= stage_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            if (push) mem_q[wr_q[AW-1:0]] <= commit_val;
        end
    end

    assign data_valid_o = !empty;
    assign data_data_o  = mem_q[rd_q[AW-1:0]];
    assign fill_o       = FW'(wr_q - rd_q);
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_config_write_fifo_register.sv
// tb/tb_config_write_fifo_register.sv - directed self-checking bench for config_write_fifo_register
module tb_config_write_fifo_register;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 96-bit payload, two config words at 0x100/0x101, control at 0x102.
    logic        a_cv, a_dv, a_rdy, a_ovf;
    logic [31:0] a_ca;
    logic [63:0] a_cd;
    logic [95:0] a_dd;
    logic [2:0]  a_fill;
    logic [15:0] a_drop;

    // Instance B: 32-bit payload at 0x40, control at 0x41, 2-bit drop counter.
    logic        b_cv, b_dv, b_rdy, b_ovf;
    logic [31:0] b_ca;
    logic [63:0] b_cd;
    logic [31:0] b_dd;
    logic [2:0]  b_fill;
    logic [1:0]  b_drop;

    int n_cmp = 0;
    int n_bad = 0;

    config_write_fifo_register #(
        .ADDR(32'h100), .TYPE(logic [95:0]), .DEPTH(4), .DROP_CNT_WIDTH(16)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .conf_valid_i(a_cv), .conf_addr_i(a_ca), .conf_data_i(a_cd),
        .data_valid_o(a_dv), .data_ready_i(a_rdy), .data_data_o(a_dd), .fill_o(a_fill),
        .overflow_o(a_ovf), .drop_count_o(a_drop)
    );

    config_write_fifo_register #(
        .ADDR(32'h40), .TYPE(logic [31:0]), .DEPTH(4), .DROP_CNT_WIDTH(2)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .conf_valid_i(b_cv), .conf_addr_i(b_ca), .conf_data_i(b_cd),
        .data_valid_o(b_dv), .data_ready_i(b_rdy), .data_data_o(b_dd), .fill_o(b_fill),
        .overflow_o(b_ovf), .drop_count_o(b_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_cv = 0; a_ca = '0; a_cd = '0; a_rdy = 0;
        b_cv = 0; b_ca = '0; b_cd = '0; b_rdy = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wr_a(input logic [31:0] addr, input logic [63:0] data);
        a_cv = 1'b1; a_ca = addr; a_cd = data;
        tick();
        a_cv = 1'b0;
    endtask

    task automatic wr_b(input logic [31:0] addr, input logic [63:0] data);
        b_cv = 1'b1; b_ca = addr; b_cd = data;
        tick();
        b_cv = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (a_dv !== 1'b0) begin n_bad++; $display("FAIL reset_a_valid got %b want 0", a_dv); end
        n_cmp++; if (a_fill !== 3'd0) begin n_bad++; $display("FAIL reset_a_fill got %0d want 0", a_fill); end
        n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_a_ovf got %b want 0", a_ovf); end
        n_cmp++; if (a_drop !== 16'd0) begin n_bad++; $display("FAIL reset_a_drop got %0d want 0", a_drop); end
        n_cmp++; if (a_dd !== 96'd0) begin n_bad++; $display("FAIL reset_a_data got %h want 0", a_dd); end
        n_cmp++; if (b_dv !== 1'b0) begin n_bad++; $display("FAIL reset_b_valid got %b want 0", b_dv); end
        n_cmp++; if (b_dd !== 32'd0) begin n_bad++; $display("FAIL reset_b_data got %h want 0", b_dd); end
    endtask

    task automatic test_single_word();
        logic [31:0] vals [3];
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        do_reset();
        b_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_cv = 1'b1; b_ca = 32'h40; b_cd = 64'(vals[k]);
            tick();
            n_cmp++; if (b_dv !== 1'b1) begin n_bad++; $display("FAIL single_valid[%0d] got %b want 1", k, b_dv); end
            n_cmp++; if (b_dd !== vals[k]) begin n_bad++; $display("FAIL single_data[%0d] got %h want %h", k, b_dd, vals[k]); end
            n_cmp++; if (b_fill !== 3'd1) begin n_bad++; $display("FAIL single_fill[%0d] got %0d want 1", k, b_fill); end
        end
        b_cv = 1'b0;
        tick();
        n_cmp++; if (b_dv !== 1'b0) begin n_bad++; $display("FAIL single_drained got %b want 0", b_dv); end
        n_cmp++; if (b_fill !== 3'd0) begin n_bad++; $display("FAIL single_fill_end got %0d want 0", b_fill); end
    endtask

    task automatic test_multi_word();
        do_reset();
        wr_a(32'h101, 64'h1111);
        n_cmp++; if (a_fill !== 3'd1) begin n_bad++; $display("FAIL multi_fill1 got %0d want 1", a_fill); end
        wr_a(32'h100, 64'h2222);
        n_cmp++; if (a_fill !== 3'd1) begin n_bad++; $display("FAIL multi_nopush got %0d want 1", a_fill); end
        wr_a(32'h101, 64'h3333);
        n_cmp++; if (a_fill !== 3'd2) begin n_bad++; $display("FAIL multi_fill2 got %0d want 2", a_fill); end
        n_cmp++; if (a_dd !== {32'h1111, 64'h0}) begin n_bad++; $display("FAIL multi_head1 got %h want %h", a_dd, {32'h1111, 64'h0}); end
        a_rdy = 1'b1;
        tick();
        n_cmp++; if (a_dd !== {32'h3333, 64'h2222}) begin n_bad++; $display("FAIL multi_head2 got %h want %h", a_dd, {32'h3333, 64'h2222}); end
        tick();
        n_cmp++; if (a_dv !== 1'b0) begin n_bad++; $display("FAIL multi_drained got %b want 0", a_dv); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            wr_a(32'h101, {32'hDEADBEEF, 32'(k)});
            if (k == 5) begin
                n_cmp++; if (a_drop !== 16'd1) begin n_bad++; $display("FAIL ovf_drop_mid got %0d want 1", a_drop); end
            end
        end
        n_cmp++; if (a_fill !== 3'd4) begin n_bad++; $display("FAIL ovf_fill got %0d want 4", a_fill); end
        n_cmp++; if (a_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", a_ovf); end
        n_cmp++; if (a_drop !== 16'd2) begin n_bad++; $display("FAIL ovf_drop got %0d want 2", a_drop); end
        a_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if (a_dd !== {32'(k), 64'h0}) begin n_bad++; $display("FAIL ovf_drain[%0d] got %h want %h", k, a_dd, {32'(k), 64'h0}); end
            tick();
        end
        n_cmp++; if (a_dv !== 1'b0) begin n_bad++; $display("FAIL ovf_drained got %b want 0", a_dv); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int k = 0; k < 4; k++) wr_a(32'h101, 64'h11 + 64'(k));
        n_cmp++; if (a_fill !== 3'd4) begin n_bad++; $display("FAIL fullpop_fill0 got %0d want 4", a_fill); end
        a_rdy = 1'b1;
        wr_a(32'h101, 64'h15);
        n_cmp++; if (a_fill !== 3'd4) begin n_bad++; $display("FAIL fullpop_fill got %0d want 4", a_fill); end
        n_cmp++; if (a_drop !== 16'd0) begin n_bad++; $display("FAIL fullpop_drop got %0d want 0", a_drop); end
        n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL fullpop_ovf got %b want 0", a_ovf); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (a_dd !== {32'h12 + 32'(k), 64'h0}) begin n_bad++; $display("FAIL fullpop_order[%0d] got %h want %h", k, a_dd, {32'h12 + 32'(k), 64'h0}); end
            tick();
        end
        n_cmp++; if (a_dv !== 1'b0) begin n_bad++; $display("FAIL fullpop_drained got %b want 0", a_dv); end
    endtask

    task automatic test_control();
        do_reset();
        wr_a(32'h100, 64'h77);
        for (int k = 1; k <= 6; k++) wr_a(32'h101, 64'(k));
        wr_a(32'h102, 64'h2);
        n_cmp++; if (a_fill !== 3'd0) begin n_bad++; $display("FAIL ctrl_flush_fill got %0d want 0", a_fill); end
        n_cmp++; if (a_ovf !== 1'b1) begin n_bad++; $display("FAIL ctrl_flush_keeps_ovf got %b want 1", a_ovf); end
        n_cmp++; if (a_drop !== 16'd2) begin n_bad++; $display("FAIL ctrl_flush_keeps_drop got %0d want 2", a_drop); end
        wr_a(32'h101, 64'h55);
        n_cmp++; if (a_fill !== 3'd1) begin n_bad++; $display("FAIL ctrl_refill got %0d want 1", a_fill); end
        a_rdy = 1'b1;
        wr_a(32'h102, 64'hFFFF_FFFF_FFFF_FFF3);
        a_rdy = 1'b0;
        n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL ctrl_clr_ovf got %b want 0", a_ovf); end
        n_cmp++; if (a_drop !== 16'd0) begin n_bad++; $display("FAIL ctrl_clr_drop got %0d want 0", a_drop); end
        n_cmp++; if (a_fill !== 3'd0) begin n_bad++; $display("FAIL ctrl_clr_fill got %0d want 0", a_fill); end
        n_cmp++; if (a_dv !== 1'b0) begin n_bad++; $display("FAIL ctrl_clr_valid got %b want 0", a_dv); end
        wr_a(32'h103, 64'h1);
        wr_a(32'h0FF, 64'h1);
        n_cmp++; if (a_fill !== 3'd0) begin n_bad++; $display("FAIL ctrl_ignored_addr got %0d want 0", a_fill); end
        wr_a(32'h101, 64'h99);
        n_cmp++; if (a_dv !== 1'b1) begin n_bad++; $display("FAIL ctrl_retained_valid got %b want 1", a_dv); end
        n_cmp++; if (a_dd !== {32'h99, 64'h77}) begin n_bad++; $display("FAIL ctrl_retained_data got %h want %h", a_dd, {32'h99, 64'h77}); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 1; k <= 9; k++) wr_b(32'h40, 64'(k));
        n_cmp++; if (b_fill !== 3'd4) begin n_bad++; $display("FAIL sat_fill got %0d want 4", b_fill); end
        n_cmp++; if (b_ovf !== 1'b1) begin n_bad++; $display("FAIL sat_ovf got %b want 1", b_ovf); end
        n_cmp++; if (b_drop !== 2'd3) begin n_bad++; $display("FAIL sat_drop got %0d want 3", b_drop); end
        n_cmp++; if (b_dd !== 32'd1) begin n_bad++; $display("FAIL sat_head got %h want 1", b_dd); end
    endtask

    task automatic test_async_reset();
        do_reset();
        wr_a(32'h100, 64'h77);
        for (int k = 1; k <= 5; k++) wr_a(32'h101, 64'(k));
        a_rdy = 1'b1;
        tick();
        a_rdy = 1'b0;
        n_cmp++; if (a_fill !== 3'd3) begin n_bad++; $display("FAIL areset_pre_fill got %0d want 3", a_fill); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a_dv !== 1'b0) begin n_bad++; $display("FAIL areset_valid got %b want 0", a_dv); end
        n_cmp++; if (a_fill !== 3'd0) begin n_bad++; $display("FAIL areset_fill got %0d want 0", a_fill); end
        n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("FAIL areset_ovf got %b want 0", a_ovf); end
        n_cmp++; if (a_drop !== 16'd0) begin n_bad++; $display("FAIL areset_drop got %0d want 0", a_drop); end
        tick();
        rst_n = 1'b1;
        tick();
        wr_a(32'h101, 64'h5);
        n_cmp++; if (a_dv !== 1'b1) begin n_bad++; $display("FAIL areset_post_valid got %b want 1", a_dv); end
        n_cmp++; if (a_dd !== {32'h5, 64'h0}) begin n_bad++; $display("FAIL areset_staging got %h want %h", a_dd, {32'h5, 64'h0}); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word();
        test_overflow();
        test_full_pop();
        test_control();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
